// File: rtl/dtu_sync_sequencer.sv
// DTU mode sequencer: turns decoded commands into flush/synch controls, aligning
// synch entry and exit to serializer word handshakes and aborting on handshake loss.
module dtu_sync_sequencer #(
   parameter int FLUSH_CYCLES = 8,
   parameter int CNT_W        = 16,
   parameter int TO_W         = 8,
   parameter int HS_TIMEOUT   = 255
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             cmd_valid,
   input  logic [2:0]       cmd_code,
   output logic             cmd_ready,
   input  logic             hshake,
   input  logic [CNT_W-1:0] sync_words_cfg,
   output logic             flush,
   output logic             synch,
   output logic             busy,
   output logic [CNT_W-1:0] sync_cnt,
   output logic             cmd_err,
   output logic             timeout_err,
   output logic [2:0]       state_o
);

   localparam logic [2:0] CMD_FLUSH      = 3'd1;
   localparam logic [2:0] CMD_SYNC_START = 3'd2;
   localparam logic [2:0] CMD_SYNC_STOP  = 3'd3;
   localparam logic [2:0] CMD_FLUSH_SYNC = 3'd4;

   localparam int            FL_W    = $clog2(FLUSH_CYCLES + 1);
   localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(HS_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FLUSH     = 3'd1,
      ST_SYNC_WAIT = 3'd2,
      ST_SYNC      = 3'd3,
      ST_DRAIN     = 3'd4
   } state_t;

   state_t            state, state_nxt;
   logic [FL_W-1:0]   fl_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic              flush_then_sync;
   logic              accept;
   logic              stop_req;
   logic [CNT_W-1:0]  cnt_sat;
   logic              cmd_err_ev, timeout_ev, cnt_clr, cnt_inc;
   logic              flush_nxt, synch_nxt, busy_nxt;
   logic [CNT_W-1:0]  sync_cnt_nxt;

   assign cmd_ready = (state == ST_IDLE || state == ST_SYNC) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign stop_req  = accept && (cmd_code == CMD_SYNC_STOP);
   assign cnt_sat   = (sync_cnt == '1) ? sync_cnt : sync_cnt + CNT_W'(1);
   assign state_o   = state;

   always_ff @(posedge clock) begin
      if (rst) begin
         state           <= ST_IDLE;
         fl_cnt          <= '0;
         to_cnt          <= '0;
         flush_then_sync <= 1'b0;
         flush           <= 1'b0;
         synch           <= 1'b0;
         busy            <= 1'b0;
         sync_cnt        <= '0;
         cmd_err         <= 1'b0;
         timeout_err     <= 1'b0;
      end else begin
         state       <= state_nxt;
         flush       <= flush_nxt;
         synch       <= synch_nxt;
         busy        <= busy_nxt;
         sync_cnt    <= sync_cnt_nxt;
         cmd_err     <= cmd_err_ev;
         timeout_err <= timeout_ev;
         fl_cnt      <= (state == ST_FLUSH && state_nxt == ST_FLUSH) ? fl_cnt + FL_W'(1) : '0;
         // Timeout counter runs only while parked in a handshake-waiting state.
         to_cnt      <= ((state == ST_SYNC_WAIT || state == ST_DRAIN) && state_nxt == state)
                        ? to_cnt + TO_W'(1) : '0;
         if (state == ST_IDLE && accept)
            flush_then_sync <= (cmd_code == CMD_FLUSH_SYNC);
      end
   end

   always_comb begin
      state_nxt  = state;
      cmd_err_ev = 1'b0;
      timeout_ev = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               case (cmd_code)
                  CMD_FLUSH, CMD_FLUSH_SYNC: state_nxt = ST_FLUSH;
                  CMD_SYNC_START: begin
                     state_nxt = ST_SYNC_WAIT;
                     cnt_clr   = 1'b1;
                  end
                  default: cmd_err_ev = 1'b1;
               endcase
            end
         end
         ST_FLUSH: begin
            if (fl_cnt == FL_LAST) begin
               state_nxt = flush_then_sync ? ST_SYNC_WAIT : ST_IDLE;
               cnt_clr   = flush_then_sync;
            end
         end
         ST_SYNC_WAIT: begin
            if (hshake) begin
               state_nxt = ST_SYNC;
            end else if (to_cnt == TO_LAST) begin
               state_nxt  = ST_IDLE;
               timeout_ev = 1'b1;
            end
         end
         ST_SYNC: begin
            if (accept && !stop_req)
               cmd_err_ev = 1'b1;
            // A stop landing on a word boundary exits straight away, no drain needed.
            if (hshake) begin
               cnt_inc = 1'b1;
               if (stop_req || (sync_words_cfg != '0 && cnt_sat == sync_words_cfg))
                  state_nxt = ST_IDLE;
            end else if (stop_req) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (hshake) begin
               cnt_inc   = 1'b1;
               state_nxt = ST_IDLE;
            end else if (to_cnt == TO_LAST) begin
               state_nxt  = ST_IDLE;
               timeout_ev = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      flush_nxt    = (state_nxt == ST_FLUSH);
      synch_nxt    = (state_nxt == ST_SYNC) || (state_nxt == ST_DRAIN);
      busy_nxt     = (state_nxt != ST_IDLE);
      sync_cnt_nxt = sync_cnt;
      if (cnt_clr)
         sync_cnt_nxt = '0;
      else if (cnt_inc)
         sync_cnt_nxt = cnt_sat;
   end

endmodule

// File: tb/tb_dtu_sync_sequencer.sv
// Directed self-checking bench for dtu_sync_sequencer: flush window, auto-stop,
// SYNC_STOP drain and immediate exit, handshake timeouts, illegal commands, reset.
module tb_dtu_sync_sequencer;

   localparam logic [2:0] C_FLUSH = 3'd1, C_START = 3'd2, C_STOP = 3'd3, C_FSYNC = 3'd4;
   localparam int S_IDLE = 0, S_FLUSH = 1, S_WAIT = 2, S_SYNC = 3, S_DRAIN = 4;

   logic        clock = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [2:0]  cmd_code = 3'd0;
   logic        cmd_ready;
   logic        hshake = 1'b0;
   logic [15:0] sync_words_cfg = 16'd0;
   logic        flush, synch, busy, cmd_err, timeout_err;
   logic [15:0] sync_cnt;
   logic [2:0]  state_o;

   int testCount = 0;
   int failCount = 0;
   int errPulses = 0;
   int toPulses = 0;
   int bothHigh = 0;
   int flushHigh;
   int errBase, toBase;

   dtu_sync_sequencer dut (
      .clock(clock), .rst(rst), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
      .cmd_ready(cmd_ready), .hshake(hshake), .sync_words_cfg(sync_words_cfg),
      .flush(flush), .synch(synch), .busy(busy), .sync_cnt(sync_cnt),
      .cmd_err(cmd_err), .timeout_err(timeout_err), .state_o(state_o)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      errPulses += int'(cmd_err);
      toPulses  += int'(timeout_err);
      bothHigh  += int'(flush && synch);
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, let the edge consume them, then release.
   task automatic applyStimulus(input logic v, input logic [2:0] c, input logic hs);
      cmd_valid = v;
      cmd_code  = c;
      hshake    = hs;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      cmd_code  = 3'd0;
      hshake    = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 1'b0);
   endtask

   // Handshake arriving after a gap of n-1 quiet cycles.
   task automatic hsAfter(input int n);
      idle(n - 1);
      applyStimulus(1'b0, 3'd0, 1'b1);
   endtask

   initial begin
      idle(3);
      checkOutput("rst_ready", 32'(cmd_ready), 0);
      checkOutput("rst_state", 32'(state_o), S_IDLE);
      checkOutput("rst_outs", {flush, synch, busy, cmd_err, timeout_err}, 0);
      checkOutput("rst_cnt", 32'(sync_cnt), 0);
      rst = 1'b0;
      #1;
      checkOutput("ready_after_rst", 32'(cmd_ready), 1);

      // FLUSH window, with a SYNC_START held on the bus that must never be taken
      errBase = errPulses;
      applyStimulus(1'b1, C_FLUSH, 1'b0);
      checkOutput("flush_first", {flush, busy, cmd_ready}, 3'b110);
      checkOutput("flush_state", 32'(state_o), S_FLUSH);
      flushHigh = 1;
      for (int i = 0; i < 8; i++) begin
         checkOutput("flush_ready_low", 32'(cmd_ready), 0);
         applyStimulus(1'b1, C_START, 1'b0);
         if (flush) flushHigh++;
      end
      checkOutput("flush_len", 32'(flushHigh), 8);
      checkOutput("flush_end_state", 32'(state_o), S_IDLE);
      checkOutput("flush_end_outs", {flush, busy}, 0);
      checkOutput("flush_no_err", 32'(errPulses - errBase), 0);

      // Auto-stop after 4 words, handshake every 8 cycles
      sync_words_cfg = 16'd4;
      applyStimulus(1'b1, C_START, 1'b0);
      checkOutput("as_wait", {29'd0, state_o}, S_WAIT);
      checkOutput("as_wait_synch", 32'(synch), 0);
      hsAfter(8);
      checkOutput("as_enter", {synch, state_o}, {1'b1, 3'(S_SYNC)});
      checkOutput("as_cnt0", 32'(sync_cnt), 0);
      hsAfter(8); hsAfter(8); hsAfter(8);
      checkOutput("as_cnt3", {synch, sync_cnt}, {1'b1, 16'd3});
      hsAfter(8);
      checkOutput("as_exit", {synch, busy, state_o}, {2'b00, 3'(S_IDLE)});
      checkOutput("as_cnt4", 32'(sync_cnt), 4);
      idle(3);
      checkOutput("as_cnt_hold", 32'(sync_cnt), 4);

      // Open-ended sync, STOP between handshakes then drain on the next one
      sync_words_cfg = 16'd0;
      applyStimulus(1'b1, C_START, 1'b0);
      checkOutput("st_cnt_clear", 32'(sync_cnt), 0);
      hsAfter(4);
      for (int i = 0; i < 10; i++) hsAfter(4);
      checkOutput("st_cnt10", {synch, sync_cnt}, {1'b1, 16'd10});
      idle(2);
      applyStimulus(1'b1, C_STOP, 1'b0);
      checkOutput("st_drain", {synch, cmd_ready, state_o}, {2'b10, 3'(S_DRAIN)});
      idle(4);
      checkOutput("st_drain_hold", {synch, state_o}, {1'b1, 3'(S_DRAIN)});
      applyStimulus(1'b0, 3'd0, 1'b1);
      checkOutput("st_exit", {synch, state_o}, {1'b0, 3'(S_IDLE)});
      checkOutput("st_cnt11", 32'(sync_cnt), 11);

      // STOP on a handshake cycle exits immediately
      errBase = errPulses;
      applyStimulus(1'b1, C_START, 1'b0);
      hsAfter(3); hsAfter(3); hsAfter(3);
      checkOutput("imm_cnt2", 32'(sync_cnt), 2);
      applyStimulus(1'b1, C_STOP, 1'b1);
      checkOutput("imm_exit", {synch, state_o}, {1'b0, 3'(S_IDLE)});
      checkOutput("imm_cnt3", 32'(sync_cnt), 3);

      // STOP coinciding with auto-stop
      sync_words_cfg = 16'd2;
      applyStimulus(1'b1, C_START, 1'b0);
      hsAfter(2); hsAfter(2);
      applyStimulus(1'b1, C_STOP, 1'b1);
      checkOutput("co_exit", {synch, state_o, sync_cnt}, {1'b0, 3'(S_IDLE), 16'd2});
      checkOutput("co_no_err", 32'(errPulses - errBase), 0);
      sync_words_cfg = 16'd0;

      // Handshake timeout in SYNC_WAIT
      toBase = toPulses;
      applyStimulus(1'b1, C_START, 1'b0);
      idle(254);
      checkOutput("to_wait_hold", {timeout_err, state_o}, {1'b0, 3'(S_WAIT)});
      idle(1);
      checkOutput("to_wait_pulse", {timeout_err, synch, state_o}, {2'b10, 3'(S_IDLE)});
      idle(1);
      checkOutput("to_wait_once", 32'(toPulses - toBase), 1);

      // Handshake timeout in DRAIN drops synch
      applyStimulus(1'b1, C_START, 1'b0);
      hsAfter(2);
      applyStimulus(1'b1, C_STOP, 1'b0);
      idle(254);
      checkOutput("to_drain_hold", {timeout_err, synch, state_o}, {2'b01, 3'(S_DRAIN)});
      idle(1);
      checkOutput("to_drain_pulse", {timeout_err, synch, state_o}, {2'b10, 3'(S_IDLE)});
      idle(1);
      checkOutput("to_drain_once", 32'(toPulses - toBase), 2);

      // Illegal code in IDLE, FLUSH inside SYNC
      errBase = errPulses;
      applyStimulus(1'b1, 3'd7, 1'b0);
      checkOutput("ill_idle", {cmd_err, state_o}, {1'b1, 3'(S_IDLE)});
      applyStimulus(1'b1, C_START, 1'b0);
      checkOutput("ill_err_clear", 32'(cmd_err), 0);
      hsAfter(2);
      applyStimulus(1'b1, C_FLUSH, 1'b0);
      checkOutput("ill_sync", {cmd_err, flush, synch, state_o}, {3'b101, 3'(S_SYNC)});
      idle(1);
      checkOutput("ill_count", 32'(errPulses - errBase), 2);
      applyStimulus(1'b1, C_STOP, 1'b1);

      // FLUSH_SYNC: flush window then SYNC_WAIT, never both controls high
      applyStimulus(1'b1, C_FSYNC, 1'b0);
      checkOutput("fs_flush", {flush, synch}, 2'b10);
      idle(7);
      checkOutput("fs_flush_last", {flush, state_o}, {1'b1, 3'(S_FLUSH)});
      idle(1);
      checkOutput("fs_wait", {flush, synch, state_o}, {2'b00, 3'(S_WAIT)});
      checkOutput("fs_cnt_clear", 32'(sync_cnt), 0);
      hsAfter(3);
      checkOutput("fs_sync", {synch, state_o}, {1'b1, 3'(S_SYNC)});

      // Reset in the middle of SYNC
      errBase = errPulses;
      toBase = toPulses;
      hsAfter(3); hsAfter(3);
      checkOutput("rs_pre", {synch, sync_cnt}, {1'b1, 16'd2});
      rst = 1'b1;
      idle(1);
      checkOutput("rs_outs", {synch, flush, busy, cmd_ready, state_o}, {4'b0000, 3'(S_IDLE)});
      checkOutput("rs_cnt", 32'(sync_cnt), 0);
      rst = 1'b0;
      idle(2);
      checkOutput("rs_no_pulses", 32'((errPulses - errBase) + (toPulses - toBase)), 0);
      checkOutput("never_both", 32'(bothHigh), 0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
